// File: rtl/sd_crc_16.sv
// sd_crc_16: bit-serial CRC-16 generator/checker for one SD DAT lane.
// Polynomial x^16 + x^12 + x^5 + 1 (POLY excludes the implicit x^16 term),
// processed MSB-first, no reflection, no final XOR.
//
// Configuration macro: SD_CRC16_INIT_ONES_EN
//   undefined : reset/seed value 16'h0000 (SD-compliant, CRC-16/XMODEM)
//   defined   : reset/seed value 16'hFFFF (CRC-16/CCITT-FALSE)
//
// Ports (positional order is fixed; the host instantiates by position):
//   bitval : in  1  serial data bit for this cycle
//   enable : in  1  shift bitval into the CRC when high
//   sd_clk : in  1  SD card clock, rising-edge active
//   rst    : in  1  synchronous active-high clear to the seed value
//   crc    : out 16 current CRC register, driven straight from the flop
module sd_crc_16 #(
  parameter logic [15:0] POLY = 16'h1021
) (
  input  logic        bitval,
  input  logic        enable,
  input  logic        sd_clk,
  input  logic        rst,
  output logic [15:0] crc
);

  localparam int unsigned CrcW = 16;

`ifdef SD_CRC16_INIT_ONES_EN
  localparam logic [CrcW-1:0] Seed = 16'hFFFF;
`else
  localparam logic [CrcW-1:0] Seed = 16'h0000;
`endif

  logic [CrcW-1:0] crc_q;
  logic [CrcW-1:0] crc_d;
  logic            fb;

  // Next-state: one LFSR step when enabled, otherwise hold.
  always_comb begin
    crc_d = crc_q;
    fb    = bitval ^ crc_q[CrcW-1];
    if (enable) begin
      crc_d = {crc_q[CrcW-2:0], 1'b0} ^ (fb ? POLY : CrcW'(0));
    end
  end

  // State register; rst has priority over enable.
  always_ff @(posedge sd_clk) begin
    if (rst) begin
      crc_q <= Seed;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: tb/tb_sd_crc_16.sv
module tb_sd_crc_16;

  logic        bitval;
  logic        enable;
  logic        sd_clk;
  logic        rst;
  logic [15:0] crc;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  sd_crc_16 dut (
    .bitval (bitval),
    .enable (enable),
    .sd_clk (sd_clk),
    .rst    (rst),
    .crc    (crc)
  );

  initial sd_clk = 1'b0;
  always #5 sd_clk = ~sd_clk;

`ifdef SD_CRC16_INIT_ONES_EN
  localparam bit OnesSeed = 1'b1;
`else
  localparam bit OnesSeed = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        enable;
    logic        bitval;
    logic [15:0] exp_zero;  // expected with 16'h0000 seed
    logic [15:0] exp_ones;  // expected with 16'hFFFF seed
    string       name;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] check_str[9];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: crc=%h required=%h", name, act, exp);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic b);
    @(negedge sd_clk);
    rst    = r;
    enable = e;
    bitval = b;
    @(posedge sd_clk);
    #1;
  endtask

  task automatic shift_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) step(1'b0, 1'b1, d[i]);
  endtask

  task automatic shift_string_gapped(input bit gaps);
    for (int c = 0; c < 9; c++) begin
      for (int i = 7; i >= 0; i--) begin
        if (gaps) begin
          int unsigned g;
          g = $urandom_range(5, 0);
          for (int k = 0; k < int'(g); k++) step(1'b0, 1'b0, 1'($urandom_range(1, 0)));
        end
        step(1'b0, 1'b1, check_str[c][i]);
      end
    end
  endtask

  function automatic logic [15:0] pick(input logic [15:0] z, input logic [15:0] o);
    return OnesSeed ? o : z;
  endfunction

  initial begin
    logic [15:0] seed;
    seed   = pick(16'h0000, 16'hFFFF);
    rst    = 1'b0;
    enable = 1'b0;
    bitval = 1'b0;
    for (int c = 0; c < 9; c++) check_str[c] = 8'h31 + 8'(c);

    // Single-cycle vectors: {rst, enable, bitval, exp(seed 0), exp(seed 1)}
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, "reset"});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h1021, 16'hFFFE, "single_bit1"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h1021, 16'hFFFE, "hold_b1"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 16'h1021, 16'hFFFE, "hold_b0"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h2042, 16'hEFDD, "shift_b0"});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h50A5, 16'hDFBA, "shift_b1"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 16'h0000, 16'hFFFF, "rst_over_en"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h0000, 16'hEFDF, "single_bit0"});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h1021, 16'hDFBE, "seq_b1"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h2042, 16'hAF5D, "seq_b0a"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h4084, 16'h4E9B, "seq_b0b"});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].enable, vecs[i].bitval);
      check(vecs[i].name, crc, pick(vecs[i].exp_zero, vecs[i].exp_ones));
    end

    // Reset then 20 disabled cycles with toggling data.
    step(1'b1, 1'b0, 1'b0);
    check("reset_again", crc, seed);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'(i & 1));
      check("disabled_hold", crc, seed);
    end

    // Standard check value.
    step(1'b1, 1'b0, 1'b0);
    shift_string_gapped(1'b0);
    check("check_123456789", crc, pick(16'h31C3, 16'h29B1));

    // Gated enable with random gaps and random data during gaps.
    step(1'b1, 1'b0, 1'b0);
    shift_string_gapped(1'b1);
    check("gated_123456789", crc, pick(16'h31C3, 16'h29B1));

    // Mid-stream reset with enable high discards the partial CRC.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'($urandom_range(1, 0)));
    step(1'b1, 1'b1, 1'b1);
    check("midstream_rst", crc, seed);
    shift_string_gapped(1'b0);
    check("after_rst_123456789", crc, pick(16'h31C3, 16'h29B1));

    // Full SD block of 0xFF bytes (seed-zero reference value).
    if (!OnesSeed) begin
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 512; i++) shift_byte(8'hFF);
      check("sd_block_ff", crc, 16'h7FA1);
    end

    @(negedge sd_clk);
    enable = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
